// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word accesses into word-aligned, byte-enabled
// requests on a variable-latency data port and stalls the core until completion.
module load_store_unit #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]  r_state;
   logic [7:0]  r_count;
   logic [1:0]  r_addr_lo;
   logic [1:0]  r_size;
   logic        r_sign_ext;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic        r_bus_error;

   logic        w_req;
   logic        w_misaligned;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   assign w_req = req_read | req_write;

   always_comb begin
      w_misaligned = 1'b0;
      case (size)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = addr[0];
         2'b10:   w_misaligned = (addr[1:0] != 2'b00);
         default: w_misaligned = 1'b1;
      endcase
   end

   // Store data is replicated across lanes so the memory only needs the byte enables.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = 32'h0;
      case (size)
         2'b00: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b1111;
            w_wdata = wdata;
         end
         default: begin
            w_be    = 4'b0000;
            w_wdata = 32'h0;
         end
      endcase
      if (!req_write) begin
         w_wdata = 32'h0;
      end
   end

   always_comb begin
      w_byte = mem_rdata[7:0];
      case (r_addr_lo)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_size)
         2'b00:   w_load = {{24{r_sign_ext & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_sign_ext & w_half[15]}}, w_half};
         default: w_load = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_count     <= 8'd0;
         r_addr_lo   <= 2'b00;
         r_size      <= 2'b00;
         r_sign_ext  <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'h0;
         r_rdata     <= 32'h0;
         r_bus_error <= 1'b0;
      end else begin
         r_bus_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req && !w_misaligned) begin
                  r_mem_addr  <= {addr[31:2], 2'b00};
                  r_mem_we    <= req_write;
                  r_mem_be    <= w_be;
                  r_mem_wdata <= w_wdata;
                  r_mem_req   <= 1'b1;
                  r_count     <= 8'd0;
                  r_addr_lo   <= addr[1:0];
                  r_size      <= size;
                  r_sign_ext  <= sign_ext;
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_rdata   <= r_mem_we ? 32'h0 : w_load;
                  r_state   <= S_DONE;
               end else if (r_count == TIMEOUT_CYCLES - 8'd1) begin
                  r_mem_req   <= 1'b0;
                  r_rdata     <= 32'h0;
                  r_bus_error <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            // The instruction still holds its request here; returning to IDLE
            // unconditionally keeps it from launching a second access.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall      = reset & (((r_state == S_IDLE) & w_req & ~w_misaligned) |
                                (r_state == S_ACCESS));
   assign misaligned = reset & (r_state == S_IDLE) & w_req & w_misaligned;
   assign rdata      = r_rdata;
   assign bus_error  = r_bus_error;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_be     = r_mem_be;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected request
// and completion records; a negedge monitor pops and compares them.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        berr;
      int          stalls;
   } comp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_read = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic        sel = 1'b0;

   logic [31:0] rdata0, rdata1, mem_addr0, mem_addr1, mem_wdata0, mem_wdata1;
   logic        stall0, stall1, mis0, mis1, berr0, berr1;
   logic        mem_req0, mem_req1, mem_we0, mem_we1;
   logic [3:0]  mem_be0, mem_be1;

   logic [31:0] m_rdata, m_mem_addr, m_mem_wdata;
   logic        m_stall, m_mis, m_berr, m_mem_req, m_mem_we;
   logic [3:0]  m_mem_be;

   int errors = 0;
   int checks = 0;
   req_t  req_q[$];
   comp_t comp_q[$];

   always #5 clk = ~clk;

   load_store_unit dut0 (
      .clk(clk), .reset(reset),
      .req_read(req_read & ~sel), .req_write(req_write & ~sel),
      .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
      .rdata(rdata0), .stall(stall0), .misaligned(mis0), .bus_error(berr0),
      .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_be(mem_be0),
      .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   load_store_unit #(.TIMEOUT_CYCLES(8'd4)) dut1 (
      .clk(clk), .reset(reset),
      .req_read(req_read & sel), .req_write(req_write & sel),
      .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .stall(stall1), .misaligned(mis1), .bus_error(berr1),
      .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_be(mem_be1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   assign m_rdata     = sel ? rdata1     : rdata0;
   assign m_stall     = sel ? stall1     : stall0;
   assign m_mis       = sel ? mis1       : mis0;
   assign m_berr      = sel ? berr1      : berr0;
   assign m_mem_req   = sel ? mem_req1   : mem_req0;
   assign m_mem_we    = sel ? mem_we1    : mem_we0;
   assign m_mem_addr  = sel ? mem_addr1  : mem_addr0;
   assign m_mem_be    = sel ? mem_be1    : mem_be0;
   assign m_mem_wdata = sel ? mem_wdata1 : mem_wdata0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: request records pop on a rising mem_req, completion records pop
   // when stall falls after an access.
   int  stall_cnt = 0;
   logic prev_stall = 1'b0, prev_req = 1'b0, prev_done = 1'b0;
   always @(negedge clk) begin
      req_t  r;
      comp_t c;
      if (!reset) begin
         stall_cnt  = 0;
         prev_stall = 1'b0;
         prev_req   = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_done) chk("bus_error_fall", {31'h0, m_berr}, 32'h0);
         prev_done = 1'b0;
         if (m_mem_req && !prev_req) begin
            if (req_q.size() == 0) begin
               chk("unexpected_req", 32'h1, 32'h0);
            end else begin
               r = req_q.pop_front();
               chk("mem_addr",  m_mem_addr, r.addr);
               chk("mem_be",    {28'h0, m_mem_be}, {28'h0, r.be});
               chk("mem_we",    {31'h0, m_mem_we}, {31'h0, r.we});
               chk("mem_wdata", m_mem_wdata, r.wdata);
            end
         end
         if (m_stall) begin
            stall_cnt++;
         end else if (prev_stall) begin
            if (comp_q.size() == 0) begin
               chk("unexpected_done", 32'h1, 32'h0);
            end else begin
               c = comp_q.pop_front();
               chk("rdata",     m_rdata, c.rdata);
               chk("bus_error", {31'h0, m_berr}, {31'h0, c.berr});
               chk("stall_cycles", 32'(stall_cnt), 32'(c.stalls));
               $display("txn done: dut%0d rdata=%h bus_error=%0b stalls=%0d", sel, m_rdata, m_berr, stall_cnt);
            end
            prev_done = 1'b1;
            stall_cnt = 0;
         end
         prev_stall = m_stall;
         prev_req   = m_mem_req;
      end
   end

   task automatic do_access(
      input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd, input int delay,
      input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
      input logic [31:0] e_rdata, input logic e_berr, input int e_stalls);
      req_t  r;
      comp_t c;
      logic  done;
      r.addr = e_addr; r.be = e_be; r.we = wr; r.wdata = e_wdata;
      c.rdata = e_rdata; c.berr = e_berr; c.stalls = e_stalls;
      req_q.push_back(r);
      comp_q.push_back(c);
      @(posedge clk); #1;
      req_read = rd; req_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
      @(posedge clk);
      done = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (!m_stall) begin
            done = 1'b1;
            break;
         end
         mem_rdata = mrd;
         mem_ready = (k == delay);
         // Address/data must not track the core's inputs mid-access.
         addr = ~a; wdata = ~wd;
      end
      mem_ready = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL access_timeout: got stall=1 after 300 cycles expected stall=0");
      end
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b0;
   endtask

   initial begin
      // Reset with a request pending: stall and misaligned must stay low.
      req_read = 1'b1; size = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall",      {31'h0, stall0}, 32'h0);
      chk("rst_misaligned", {31'h0, mis0}, 32'h0);
      chk("rst_mem_req",    {31'h0, mem_req0}, 32'h0);
      chk("rst_mem_we",     {31'h0, mem_we0}, 32'h0);
      chk("rst_mem_addr",   mem_addr0, 32'h0);
      chk("rst_mem_be",     {28'h0, mem_be0}, 32'h0);
      chk("rst_mem_wdata",  mem_wdata0, 32'h0);
      chk("rst_rdata",      rdata0, 32'h0);
      chk("rst_bus_error",  {31'h0, berr0}, 32'h0);
      req_read = 1'b0; size = 2'b00;
      @(posedge clk); #1;
      reset = 1'b1;

      //        rd    wr    sz     sx    addr          wdata         mem_rdata     dly
      //        exp_addr      be       exp_wdata     exp_rdata     berr  stalls
      do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, 32'h0,        1,
                32'h10010004, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 2);
      do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h10010003, 32'h0,        32'h80112233, 1,
                32'h10010000, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 2);
      do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10010003, 32'h0,        32'h80112233, 1,
                32'h10010000, 4'b1000, 32'h0,        32'h00000080, 1'b0, 2);
      do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h10010002, 32'h0000ABCD, 32'h0,        1,
                32'h10010000, 4'b1100, 32'hABCDABCD, 32'h00000000, 1'b0, 2);
      do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h10010002, 32'h0,        32'hABCD0000, 1,
                32'h10010000, 4'b1100, 32'h0,        32'hFFFFABCD, 1'b0, 2);
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0,        32'h12345678, 5,
                32'h10010008, 4'b1111, 32'h0,        32'h12345678, 1'b0, 6);
      do_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h10010001, 32'h000000A5, 32'hFFFFFFFF, 2,
                32'h10010000, 4'b0010, 32'hA5A5A5A5, 32'h00000000, 1'b0, 3);
      do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h10010000, 32'h0,        32'h0000F00F, 1,
                32'h10010000, 4'b0011, 32'h0,        32'h0000F00F, 1'b0, 2);

      // Short-timeout instance: one good load, then a load that never completes.
      @(posedge clk); #1; sel = 1'b1;
      do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h10010001, 32'h0,        32'h0000FE00, 1,
                32'h10010000, 4'b0010, 32'h0,        32'hFFFFFFFE, 1'b0, 2);
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0,        32'h0,        0,
                32'h10010010, 4'b1111, 32'h0,        32'h00000000, 1'b1, 5);
      @(posedge clk); #1; sel = 1'b0;

      // Misaligned requests never reach memory.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         req_read  = (i != 1);
         req_write = (i == 1);
         size = (i == 0) ? 2'b10 : (i == 1) ? 2'b11 : 2'b01;
         addr = (i == 0) ? 32'h10010001 : (i == 1) ? 32'h10010000 : 32'h10010003;
         @(negedge clk);
         chk("mis_flag",    {31'h0, mis0}, 32'h1);
         chk("mis_stall",   {31'h0, stall0}, 32'h0);
         @(negedge clk);
         chk("mis_mem_req", {31'h0, mem_req0}, 32'h0);
         req_read = 1'b0; req_write = 1'b0;
      end

      // Reset in the middle of an access, then a stray mem_ready in IDLE.
      begin
         req_t r;
         r.addr = 32'h10010020; r.be = 4'b1111; r.we = 1'b0; r.wdata = 32'h0;
         req_q.push_back(r);
      end
      @(posedge clk); #1;
      req_read = 1'b1; size = 2'b10; addr = 32'h10010020;
      @(posedge clk);
      @(negedge clk);
      chk("mid_mem_req_high", {31'h0, mem_req0}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b0; req_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_mem_req_drop", {31'h0, mem_req0}, 32'h0);
      chk("mid_stall",        {31'h0, stall0}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("late_ready_rdata", rdata0, 32'h0);
      chk("late_ready_berr",  {31'h0, berr0}, 32'h0);
      chk("late_ready_req",   {31'h0, mem_req0}, 32'h0);

      repeat (2) @(posedge clk);
      chk("req_q_drained",  32'(req_q.size()), 32'h0);
      chk("comp_q_drained", 32'(comp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1, "watchdog");
   end

endmodule
